// File: rtl/npu_stream_sequencer.sv
// npu_stream_sequencer: pushes config and input ROM contents into an NPU, then drains
// its results and checks them against an expected-value ROM within +/-TOL.
// state | meaning
// IDLE  | waiting for start
// CFG   | pushing config words
// IN    | pushing input words
// CHK   | draining and comparing results
// DONE  | finished, pass/err_count/timeout valid; start restarts
module npu_stream_sequencer #(
  parameter int CFG_WIDTH  = 26,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = 11,
  parameter int CFG_WORDS  = 312,
  parameter int IN_WORDS   = 4,
  parameter int OUT_WORDS  = 1,
  parameter int TOL        = 0,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  output logic [ADDR_W-1:0]     cfg_rom_addr,
  input  logic [CFG_WIDTH-1:0]  cfg_rom_data,
  output logic [CFG_WIDTH-1:0]  npu_config_data,
  output logic                  npu_config_fifo_write_enable,
  input  logic                  npu_config_fifo_full,
  output logic [ADDR_W-1:0]     in_rom_addr,
  input  logic [DATA_WIDTH-1:0] in_rom_data,
  output logic [DATA_WIDTH-1:0] npu_input_data,
  output logic                  npu_input_fifo_write_enable,
  input  logic                  npu_input_fifo_full,
  output logic [ADDR_W-1:0]     exp_rom_addr,
  input  logic [DATA_WIDTH-1:0] exp_rom_data,
  input  logic [DATA_WIDTH-1:0] npu_output_data,
  input  logic                  npu_output_fifo_empty,
  output logic                  npu_output_fifo_read_enable,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic                  timeout
);
  localparam int HW = (CFG_WIDTH > DATA_WIDTH) ? CFG_WIDTH : DATA_WIDTH;
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0]         CFG_N    = CW'(CFG_WORDS);
  localparam logic [CW-1:0]         IN_N     = CW'(IN_WORDS);
  localparam logic [CW-1:0]         OUT_N    = CW'(OUT_WORDS);
  localparam logic [ADDR_W-1:0]     CFG_LAST = ADDR_W'(CFG_WORDS - 1);
  localparam logic [ADDR_W-1:0]     IN_LAST  = ADDR_W'(IN_WORDS - 1);
  localparam logic [ADDR_W-1:0]     OUT_LAST = ADDR_W'(OUT_WORDS - 1);
  localparam logic [16:0]           WD_LAST  = 17'(TIMEOUT - 1);
  localparam logic [DATA_WIDTH-1:0] TOL_V    = DATA_WIDTH'(TOL);

  typedef enum logic [2:0] {S_IDLE, S_CFG, S_IN, S_CHK, S_DONE} state_t;
  state_t state;

  logic [CW-1:0]         nxt, acc_cnt, rd_cnt, cmp_cnt;
  logic                  pend, hold_valid, rd_pend;
  logic [HW-1:0]         hold_data;
  logic [16:0]           wd;

  logic                  in_cfg, in_in, in_push, in_chk;
  logic [CW-1:0]         n_words, nxt_n, rd_cnt_n;
  logic [ADDR_W-1:0]     last_a, addr_n, exp_addr_n;
  logic                  accepted, push_last, slot_ok, fetch, rewind, load;
  logic [DATA_WIDTH-1:0] diff;
  logic [15:0]           err_n;
  logic                  chk_last, progress, wd_fire;

  assign in_cfg  = (state == S_CFG);
  assign in_in   = (state == S_IN);
  assign in_push = in_cfg | in_in;
  assign in_chk  = (state == S_CHK);

  assign n_words = in_cfg ? CFG_N : IN_N;
  assign last_a  = in_cfg ? CFG_LAST : IN_LAST;

  assign npu_config_fifo_write_enable = in_cfg & hold_valid & ~npu_config_fifo_full;
  assign npu_input_fifo_write_enable  = in_in & hold_valid & ~npu_input_fifo_full;
  assign npu_config_data = hold_data[CFG_WIDTH-1:0];
  assign npu_input_data  = hold_data[DATA_WIDTH-1:0];

  assign accepted  = npu_config_fifo_write_enable | npu_input_fifo_write_enable;
  assign push_last = accepted & (acc_cnt == n_words - CW'(1));
  assign slot_ok   = ~hold_valid | accepted;
  assign fetch     = in_push & slot_ok & (nxt < n_words);
  // Fetched data that cannot land in a still-occupied hold register is dropped and re-fetched.
  assign rewind    = in_push & pend & ~slot_ok;
  assign load      = in_push & pend & slot_ok;
  assign nxt_n     = rewind ? nxt - CW'(1) : (fetch ? nxt + CW'(1) : nxt);
  assign addr_n    = (nxt_n >= n_words) ? last_a : nxt_n[ADDR_W-1:0];

  assign npu_output_fifo_read_enable = in_chk & ~npu_output_fifo_empty & (rd_cnt < OUT_N);
  assign rd_cnt_n   = rd_cnt + CW'(npu_output_fifo_read_enable);
  assign exp_addr_n = (rd_cnt_n >= OUT_N) ? OUT_LAST : rd_cnt_n[ADDR_W-1:0];
  assign diff       = (npu_output_data >= exp_rom_data) ? npu_output_data - exp_rom_data
                                                        : exp_rom_data - npu_output_data;
  assign err_n      = err_count + 16'(rd_pend & (diff > TOL_V) & ~(&err_count));
  assign chk_last   = rd_pend & (cmp_cnt == OUT_N - CW'(1));

  assign progress = accepted | npu_output_fifo_read_enable;
  assign wd_fire  = (in_push | in_chk) & ~progress & (wd == WD_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_IDLE;
      nxt          <= '0;
      acc_cnt      <= '0;
      rd_cnt       <= '0;
      cmp_cnt      <= '0;
      pend         <= 1'b0;
      hold_valid   <= 1'b0;
      hold_data    <= '0;
      rd_pend      <= 1'b0;
      wd           <= '0;
      cfg_rom_addr <= '0;
      in_rom_addr  <= '0;
      exp_rom_addr <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_count    <= '0;
      timeout      <= 1'b0;
    end else begin
      if (in_push | in_chk) wd <= progress ? '0 : wd + 17'd1;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state        <= S_CFG;
            nxt          <= '0;
            acc_cnt      <= '0;
            rd_cnt       <= '0;
            cmp_cnt      <= '0;
            pend         <= 1'b0;
            hold_valid   <= 1'b0;
            rd_pend      <= 1'b0;
            wd           <= '0;
            cfg_rom_addr <= '0;
            in_rom_addr  <= '0;
            exp_rom_addr <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            timeout      <= 1'b0;
          end
        end
        S_CFG, S_IN: begin
          pend       <= fetch;
          hold_valid <= load | (hold_valid & ~accepted);
          if (load) hold_data <= in_cfg ? HW'(cfg_rom_data) : HW'(in_rom_data);
          nxt     <= nxt_n;
          acc_cnt <= acc_cnt + CW'(accepted);
          if (in_cfg) cfg_rom_addr <= addr_n;
          else        in_rom_addr  <= addr_n;
          if (push_last) begin
            nxt        <= '0;
            acc_cnt    <= '0;
            pend       <= 1'b0;
            hold_valid <= 1'b0;
            state      <= in_cfg ? S_IN : S_CHK;
          end
        end
        S_CHK: begin
          rd_pend      <= npu_output_fifo_read_enable;
          rd_cnt       <= rd_cnt_n;
          exp_rom_addr <= exp_addr_n;
          if (rd_pend) cmp_cnt <= cmp_cnt + CW'(1);
          err_count <= err_n;
          if (chk_last) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_n == 16'd0);
          end
        end
        default: state <= S_IDLE;
      endcase
      if (wd_fire) begin
        state      <= S_DONE;
        busy       <= 1'b0;
        done       <= 1'b1;
        pass       <= 1'b0;
        timeout    <= 1'b1;
        pend       <= 1'b0;
        hold_valid <= 1'b0;
        rd_pend    <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_npu_stream_sequencer.sv
// Randomized self-checking bench for npu_stream_sequencer: ROM and FIFO models around the DUT,
// expected behaviour derived from ROM contents, result values and cycle arithmetic.
module tb_npu_stream_sequencer;
  localparam int C    = 5;
  localparam int I    = 4;
  localparam int O    = 3;
  localparam int TOLV = 1;
  localparam int TO   = 40;
  localparam int AW   = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] cfg_rom_addr, in_rom_addr, exp_rom_addr;
  logic [25:0]   cfg_rom_data = '0;
  logic [25:0]   npu_config_data;
  logic          cfg_we, in_we, rd_en;
  logic          npu_config_fifo_full = 1'b0;
  logic [31:0]   in_rom_data = '0;
  logic [31:0]   npu_input_data;
  logic          npu_input_fifo_full = 1'b0;
  logic [31:0]   exp_rom_data = '0;
  logic [31:0]   npu_output_data = '0;
  logic          npu_output_fifo_empty = 1'b1;
  logic          busy, done, pass, timeout;
  logic [15:0]   err_count;

  npu_stream_sequencer #(
    .CFG_WIDTH(26), .DATA_WIDTH(32), .ADDR_W(AW), .CFG_WORDS(C), .IN_WORDS(I),
    .OUT_WORDS(O), .TOL(TOLV), .TIMEOUT(TO)
  ) u_dut (
    .CLK(CLK), .RST(RST), .start(start),
    .cfg_rom_addr(cfg_rom_addr), .cfg_rom_data(cfg_rom_data),
    .npu_config_data(npu_config_data), .npu_config_fifo_write_enable(cfg_we),
    .npu_config_fifo_full(npu_config_fifo_full),
    .in_rom_addr(in_rom_addr), .in_rom_data(in_rom_data),
    .npu_input_data(npu_input_data), .npu_input_fifo_write_enable(in_we),
    .npu_input_fifo_full(npu_input_fifo_full),
    .exp_rom_addr(exp_rom_addr), .exp_rom_data(exp_rom_data),
    .npu_output_data(npu_output_data), .npu_output_fifo_empty(npu_output_fifo_empty),
    .npu_output_fifo_read_enable(rd_en),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .timeout(timeout)
  );

  initial forever #5 CLK = ~CLK;

  logic [25:0] cfg_rom [16];
  logic [31:0] in_rom [16];
  logic [31:0] exp_rom [16];
  logic [31:0] res_arr [16];
  logic [31:0] res_q [$];
  logic [25:0] cfg_seen [$];
  logic [31:0] in_seen [$];
  int          cfg_cyc [$];
  int          in_cyc [$];
  logic [AW-1:0] a_cfg = '0, a_in = '0, a_exp = '0;
  logic [31:0] rd_val = '0;
  bit          rd_pend = 1'b0;
  bit          stall = 1'b0, fwin = 1'b0;
  int          cyc = 0, s_cyc = 0, last_prog = 0, done_cyc = -1, prot_err = 0;
  int          n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: ROM/FIFO models update just after the edge, DUT outputs sampled at the falling edge.
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    cfg_rom_data = cfg_rom[a_cfg];
    in_rom_data  = in_rom[a_in];
    exp_rom_data = exp_rom[a_exp];
    if (rd_pend) npu_output_data = rd_val;
    rd_pend = 1'b0;
    if (fwin) npu_config_fifo_full = (cyc >= s_cyc + 4) && (cyc <= s_cyc + 8);
    else      npu_config_fifo_full = stall && ($urandom_range(0, 9) < 3);
    npu_input_fifo_full   = stall && ($urandom_range(0, 9) < 3);
    npu_output_fifo_empty = (res_q.size() == 0) || (stall && ($urandom_range(0, 9) < 3));
    @(negedge CLK);
    a_cfg = cfg_rom_addr;
    a_in  = in_rom_addr;
    a_exp = exp_rom_addr;
    if (cfg_we) begin
      if (npu_config_fifo_full) prot_err++;
      cfg_seen.push_back(npu_config_data);
      cfg_cyc.push_back(cyc);
      last_prog = cyc;
    end
    if (in_we) begin
      if (npu_input_fifo_full) prot_err++;
      in_seen.push_back(npu_input_data);
      in_cyc.push_back(cyc);
      last_prog = cyc;
    end
    if (rd_en) begin
      if (res_q.size() == 0) prot_err++;
      else rd_val = res_q.pop_front();
      rd_pend   = 1'b1;
      last_prog = cyc;
    end
    if (done && done_cyc < 0) done_cyc = cyc;
  endtask

  function automatic int exp_errs(input int n);
    int e = 0;
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      d = (res_arr[i] > exp_rom[i]) ? res_arr[i] - exp_rom[i] : exp_rom[i] - res_arr[i];
      if (d > 32'(TOLV)) e++;
    end
    return e;
  endfunction

  task automatic fill_roms();
    for (int i = 0; i < 16; i++) begin
      cfg_rom[i] = 26'($urandom());
      in_rom[i]  = $urandom();
      exp_rom[i] = $urandom();
      res_arr[i] = exp_rom[i];
    end
  endtask

  task automatic begin_run(input int n_res, input bit st, input bit fw);
    cfg_seen.delete(); in_seen.delete(); cfg_cyc.delete(); in_cyc.delete(); res_q.delete();
    for (int i = 0; i < n_res; i++) res_q.push_back(res_arr[i]);
    stall = st; fwin = fw; done_cyc = -1; prot_err = 0;
    start = 1'b1;
    s_cyc = cyc;
    last_prog = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic run(input int n_res, input bit st, input bit fw);
    int  n_cmp, errs;
    bit  exp_to;
    begin_run(n_res, st, fw);
    check("start_flags", {busy, done, pass, timeout}, 4'b1000);
    check("start_err_clear", err_count, 0);
    for (int i = 0; i < 3000 && done_cyc < 0; i++) tick();
    check("done_reached", done_cyc >= 0, 1);
    exp_to = (n_res < O);
    n_cmp  = exp_to ? n_res : O;
    errs   = exp_errs(n_cmp);
    check("cfg_count", cfg_seen.size(), C);
    for (int j = 0; j < cfg_seen.size() && j < C; j++) check("cfg_word", cfg_seen[j], cfg_rom[j]);
    check("in_count", in_seen.size(), I);
    for (int j = 0; j < in_seen.size() && j < I; j++) check("in_word", in_seen[j], in_rom[j]);
    check("push_while_full", prot_err, 0);
    if (!st && !fw) begin
      for (int j = 0; j < cfg_cyc.size(); j++) check("cfg_push_cycle", cfg_cyc[j] - s_cyc, 3 + j);
      for (int j = 0; j < in_cyc.size(); j++)  check("in_push_cycle", in_cyc[j] - s_cyc, 5 + C + j);
    end
    if (exp_to) check("timeout_latency", done_cyc - last_prog, TO + 1);
    check("err_count", err_count, errs);
    check("timeout", timeout, exp_to);
    check("pass", pass, (!exp_to && errs == 0));
    check("done_flags", {busy, done, cfg_we, in_we, rd_en}, 5'b01000);
    check("cfg_addr_hold", cfg_rom_addr, C - 1);
    check("in_addr_hold", in_rom_addr, I - 1);
  endtask

  initial begin
    fill_roms();
    repeat (3) tick();
    check("rst_flags", {busy, done, pass, timeout, cfg_we, in_we, rd_en}, 0);
    check("rst_regs", {err_count, cfg_rom_addr, in_rom_addr, exp_rom_addr}, 0);
    check("rst_data", {npu_config_data, npu_input_data}, 0);
    RST = 1'b0;
    tick();

    // Tolerance boundary: diffs 0,1,0 pass with TOL=1; diff 2 fails.
    exp_rom[0] = 10; exp_rom[1] = 21; exp_rom[2] = 30;
    res_arr[0] = 10; res_arr[1] = 20; res_arr[2] = 30;
    run(O, 1'b0, 1'b0);
    res_arr[1] = 23;
    run(O, 1'b0, 1'b0);

    // Config full held high in CFG cycles 3..7.
    fill_roms();
    run(O, 1'b0, 1'b1);

    // No results ever arrive: watchdog fires after TO idle cycles.
    run(0, 1'b0, 1'b0);
    fill_roms();
    run(1, 1'b0, 1'b0);

    // Reset in the middle of the input phase, then replay from address 0.
    fill_roms();
    begin_run(O, 1'b0, 1'b0);
    for (int i = 0; i < 200 && in_seen.size() < 2; i++) tick();
    check("mid_in_reached", in_seen.size(), 2);
    RST = 1'b1;
    tick();
    check("midrst_flags", {busy, done, pass, timeout, cfg_we, in_we, rd_en}, 0);
    check("midrst_regs", {err_count, cfg_rom_addr, in_rom_addr, exp_rom_addr}, 0);
    RST = 1'b0;
    tick();
    run(O, 1'b0, 1'b0);

    // Three mismatches, then restart straight from DONE and repeat identically.
    exp_rom[0] = 3; exp_rom[1] = 9; exp_rom[2] = 50;
    res_arr[0] = 0; res_arr[1] = 5; res_arr[2] = 100;
    run(O, 1'b0, 1'b0);
    run(O, 1'b0, 1'b0);

    // Random data, results near the expected values, random back-pressure.
    for (int r = 0; r < 6; r++) begin
      fill_roms();
      for (int i = 0; i < O; i++) begin
        int off;
        off = int'($urandom_range(0, 4)) - 2;
        if ($urandom_range(0, 3) == 0) exp_rom[i] = 32'($urandom_range(0, 1));
        res_arr[i] = ($urandom_range(0, 7) == 0) ? $urandom() : exp_rom[i] + 32'(off);
      end
      run(O, 1'b1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
